wb_lsu_master: RTL and testbench
================================

# wb_lsu_master

Wishbone initiator (master) that turns single load/store requests from the multi-cycle RISC-V core into one classic-pipelined Wishbone transfer against the combined instruction/data `main_memory` slave. It sits between the core's memory stage and the Wishbone bus. It generates byte-lane selects and replicated store data for SB/SH/SW. It extracts and sign- or zero-extends load data for LB/LH/LW/LBU/LHU. It reports misaligned or unsupported accesses and bus timeouts without hanging the core.

## Interface
- `ADDR_WIDTH`, 10 — width of `o_wb_addr` (byte address, matches slave depth 1024).
- `TIMEOUT_CYCLES`, 16 — maximum cycles from first strobe to ack before abort; must be ≥2.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_req`  in  1  request pulse; sampled only in IDLE.
- `i_we`  in  1  1 = store, 0 = load.
- `i_funct3`  in  3  RISC-V funct3. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- `i_addr`  in  32  byte address.
- `i_wdata`  in  32  store data (low byte/half/word used).
- `o_busy`  out  1  high from the cycle after acceptance until `o_done`.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  valid with `o_done`: 1 = misaligned, unsupported funct3, or timeout.
- `o_rdata`  out  32  extended load result; held until the next load completes.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each  Wishbone cycle, strobe, and write enable.
- `o_wb_addr`  out  ADDR_WIDTH  word-aligned byte address (`i_addr[ADDR_WIDTH-1:2]`, 2'b00).
- `o_wb_data`  out  32  store data.
- `o_wb_sel`  out  4  byte-lane select.
- `i_wb_ack`, `i_wb_stall`  in  1 each  slave ack and stall.
- `i_wb_data`  in  32  slave read data.

## Operation
- States: IDLE, REQ (cyc=1, stb=1), WAIT (cyc=1, stb=0), DONE (done pulse), ERR (error pulse without bus cycle).
- IDLE + `i_req`:
  - Latch `i_we`, `i_funct3`, `i_addr`, and `i_wdata`.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) or unsupported funct3 (load 3/6/7, store ≥3) → ERR. No bus activity.
  - Otherwise → REQ.
- REQ:
  - `i_wb_stall`=0 → strobe accepted; go to WAIT.
  - `i_wb_ack` in the same cycle → DONE directly.
  - `i_wb_stall`=1 → stay; stb, addr, data, and sel are held stable.
- WAIT:
  - `i_wb_ack` → capture `i_wb_data` and go to DONE.
- Ack is ignored in IDLE, ERR, and DONE.
- DONE/ERR: `o_done`=1 for one cycle, cyc=stb=0, then → IDLE.
- Timeout:
  - The counter clears on REQ entry and increments every cycle in REQ/WAIT.
  - On reaching `TIMEOUT_CYCLES` without ack: drop cyc/stb, go to DONE with `o_err`=1. `o_rdata` is unchanged.
- Store lanes:
  - SB: data = {4{wdata[7:0]}}, sel = 4'b0001 << addr[1:0].
  - SH: data = {2{wdata[15:0]}}, sel = addr[1] ? 4'b1100 : 4'b0011.
  - SW: data = wdata, sel = 4'b1111.
- Load selects are 4'b1111. Extraction uses the latched addr[1:0]:
  - Byte = data[8*addr[1:0] +: 8]; half = data[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Stores leave `o_rdata` unchanged.
- `i_req` while `o_busy` is ignored; no queuing.

## Timing
- Reset: state IDLE. `o_busy`, `o_done`, `o_err`, `o_wb_cyc`, `o_wb_stb`, and `o_wb_we` = 0. `o_wb_addr`, `o_wb_data`, `o_wb_sel`, and `o_rdata` = 0. Timeout counter = 0.
- All outputs are registered.
- Zero-stall slave acking one cycle after the strobe:
  - Cycle 0: `i_req`.
  - Cycle 1: cyc=stb=1.
  - Cycle 2: ack.
  - Cycle 3: `o_done` with `o_rdata` valid, cyc=0.
  - Latency is 3 cycles; each stall or wait cycle adds 1.
- Error without bus cycle: `o_done`+`o_err` in cycle 1.
- `o_wb_cyc` stays high continuously from REQ through the ack cycle. It deasserts on the edge after ack or timeout.
- Reset mid-transfer: cyc/stb drop on that edge, no `o_done` is issued, and a late ack is ignored.
- A new `i_req` is accepted in the cycle after `o_done` (back-to-back spacing of 4 cycles).

## Test plan
- LW addr 0x008, memory word 0xFF718393, no stall, ack at cycle 2 → `o_wb_sel`=1111, `o_done` at cycle 3, `o_rdata`=0xFF718393, `o_err`=0.
- LB addr 0x00B and LBU addr 0x00B on word 0xFF718393 → `o_rdata`=0xFFFFFFFF for LB and 0x000000FF for LBU. LH addr 0x00A → 0xFFFFFF71.
- SB addr 0x012, wdata 0x000000AB → `o_wb_we`=1, sel=0100, data=0xABABABAB. SH addr 0x012, wdata 0x1234 → sel=1100, data=0x12341234.
- LW with `i_wb_stall` high for 3 cycles, then ack 2 cycles after acceptance → stb held 4 cycles with constant addr, cyc never drops, `o_done` at cycle 7.
- LH addr 0x001 and funct3=3 load → `o_done`+`o_err` at cycle 1, `o_wb_cyc` never asserted. Ack never returned → abort after 16 cycles with `o_err`=1 and `o_rdata` unchanged.
- `i_rst` asserted at cycle 2 of a load with ack at cycle 3 → cyc=0 from cycle 3, no `o_done`, `o_busy`=0. `i_req` pulsed while busy → ignored.

Source files
------------

// File: rtl/wb_lsu_master.sv
// wb_lsu_master: Wishbone (classic pipelined) initiator for single core loads/stores.
// Turns one load/store request into one bus transfer against main_memory, builds
// byte-lane selects and replicated store data, and extends load data. Misaligned or
// unsupported requests and bus timeouts complete with o_err instead of hanging.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_req, i_we, i_funct3,    request pulse (sampled in IDLE), store flag, RISC-V funct3,
//   i_addr, i_wdata           byte address, store data
//   o_busy, o_done, o_err     busy flag, one-cycle completion pulse, error (valid with done)
//   o_rdata                   extended load result, held until the next load completes
//   o_wb_cyc/stb/we/addr/     Wishbone master outputs (all registered)
//   data/sel
//   i_wb_ack/stall/data       Wishbone slave responses
module wb_lsu_master #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_rdata,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [31:0]           o_wb_data,
  output logic [3:0]            o_wb_sel,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic [31:0]           i_wb_data
);

  localparam int unsigned      TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]    TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t        state;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [TW-1:0] tmr;

  logic          req_bad;
  logic [3:0]    sel_n;
  logic [31:0]   data_n;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  // Address bits above the slave window are not decoded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_addr[31:ADDR_WIDTH];

  // Request decode: alignment/funct3 legality, lane selects and replicated store data.
  always_comb begin
    req_bad = 1'b0;
    sel_n   = 4'b1111;
    data_n  = i_wdata;
    if (i_we) begin
      unique case (i_funct3)
        3'd0: begin
          sel_n  = 4'b0001 << i_addr[1:0];
          data_n = {4{i_wdata[7:0]}};
        end
        3'd1: begin
          req_bad = i_addr[0];
          sel_n   = i_addr[1] ? 4'b1100 : 4'b0011;
          data_n  = {2{i_wdata[15:0]}};
        end
        3'd2:    req_bad = |i_addr[1:0];
        default: req_bad = 1'b1;
      endcase
    end else begin
      unique case (i_funct3)
        3'd0, 3'd4: req_bad = 1'b0;
        3'd1, 3'd5: req_bad = i_addr[0];
        3'd2:       req_bad = |i_addr[1:0];
        default:    req_bad = 1'b1;
      endcase
    end
  end

  // Load extraction from the latched byte offset.
  always_comb begin
    ld_byte = i_wb_data[{off_q, 3'b000} +: 8];
    ld_half = i_wb_data[{off_q[1], 4'b0000} +: 16];
    unique case (f3_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {24'h0, ld_byte};
      3'd5:    ld_ext = {16'h0, ld_half};
      default: ld_ext = i_wb_data;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      tmr       <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_rdata   <= '0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      o_wb_sel  <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_req) begin
            we_q   <= i_we;
            f3_q   <= i_funct3;
            off_q  <= i_addr[1:0];
            o_busy <= 1'b1;
            if (req_bad) begin
              state  <= S_ERR;
              o_done <= 1'b1;
              o_err  <= 1'b1;
            end else begin
              state     <= S_REQ;
              tmr       <= '0;
              o_wb_cyc  <= 1'b1;
              o_wb_stb  <= 1'b1;
              o_wb_we   <= i_we;
              o_wb_addr <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
              o_wb_data <= data_n;
              o_wb_sel  <= sel_n;
            end
          end
        end
        S_REQ, S_WAIT: begin
          // Ack wins over timeout; a REQ-cycle ack skips WAIT entirely.
          if (i_wb_ack) begin
            state    <= S_DONE;
            o_done   <= 1'b1;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            if (!we_q) o_rdata <= ld_ext;
          end else if (tmr == TMR_LAST) begin
            state    <= S_DONE;
            o_done   <= 1'b1;
            o_err    <= 1'b1;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
            if (state == S_REQ && !i_wb_stall) begin
              state    <= S_WAIT;
              o_wb_stb <= 1'b0;
            end
          end
        end
        S_DONE, S_ERR: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
module tb_wb_lsu_master;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy, o_done, o_err;
  logic [31:0] o_rdata;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [9:0]  o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack, i_wb_stall;
  logic [31:0] i_wb_data;

  int total = 0;
  int bad   = 0;

  // results of the last transfer
  int          r_done_cyc, r_cyc_cycles, r_stb_cycles;
  logic        r_err, r_moved, r_done_after;
  logic [31:0] r_rdata, r_data;
  logic [3:0]  r_sel;
  logic        r_we;
  logic [9:0]  r_addr;

  wb_lsu_master #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_rdata(o_rdata), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one request at cycle 0; the slave stalls cycles 1..stalls and acks
  // wt cycles after the strobe is accepted (wt=0: same cycle as acceptance).
  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int stalls, input int wt,
                      input logic ack_en, input logic [31:0] rd);
    bit fin = 0;
    i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    r_done_cyc = -1; r_cyc_cycles = 0; r_stb_cycles = 0; r_moved = 1'b0;
    r_err = 1'b0; r_done_after = 1'b0;
    for (int c = 1; c <= 40 && !fin; c++) begin
      if (c == 1) begin
        r_sel = o_wb_sel; r_data = o_wb_data; r_we = o_wb_we; r_addr = o_wb_addr;
      end
      if (o_done) begin
        r_done_cyc = c; r_err = o_err; r_rdata = o_rdata; fin = 1;
      end else begin
        if (o_wb_cyc) r_cyc_cycles++;
        if (o_wb_stb) r_stb_cycles++;
        if (o_wb_stb && o_wb_addr !== r_addr) r_moved = 1'b1;
        i_wb_stall = (c < 1 + stalls);
        i_wb_ack   = ack_en && (c == 1 + stalls + wt);
        i_wb_data  = i_wb_ack ? rd : 32'hDEAD_BEEF;
        tick();
      end
    end
    i_wb_ack = 1'b0; i_wb_stall = 1'b0;
    tick();
    r_done_after = o_done;
  endtask

  initial begin
    i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'd0; i_addr = '0; i_wdata = '0;
    i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = '0;
    tick(); tick();
    i_rst = 1'b0;
    chk("rst_ctrl", {26'b0, o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we}, 32'h0);
    chk("rst_addr_sel", {18'b0, o_wb_addr, o_wb_sel}, 32'h0);
    chk("rst_wdata", o_wb_data, 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);

    // LW, zero-stall, ack at cycle 2
    xfer(1'b0, 3'd2, 32'h008, 32'h0, 0, 1, 1'b1, 32'hFF71_8393);
    chk("lw_done_cyc", 32'(r_done_cyc), 32'd3);
    chk("lw_rdata", r_rdata, 32'hFF71_8393);
    chk("lw_err", {31'b0, r_err}, 32'h0);
    chk("lw_sel_we", {27'b0, r_we, r_sel}, 32'h0000_000F);
    chk("lw_addr", {22'b0, r_addr}, 32'h008);
    chk("lw_cyc_cycles", 32'(r_cyc_cycles), 32'd2);
    chk("lw_done_1cyc", {31'b0, r_done_after}, 32'h0);

    xfer(1'b0, 3'd0, 32'h00B, 32'h0, 0, 1, 1'b1, 32'hFF71_8393);
    chk("lb_rdata", r_rdata, 32'hFFFF_FFFF);
    xfer(1'b0, 3'd4, 32'h00B, 32'h0, 0, 1, 1'b1, 32'hFF71_8393);
    chk("lbu_rdata", r_rdata, 32'h0000_00FF);
    xfer(1'b0, 3'd1, 32'h00A, 32'h0, 0, 1, 1'b1, 32'hFF71_8393);
    chk("lh_rdata", r_rdata, 32'hFFFF_FF71);
    xfer(1'b0, 3'd5, 32'h008, 32'h0, 0, 1, 1'b1, 32'hFF71_8393);
    chk("lhu_rdata", r_rdata, 32'h0000_8393);
    xfer(1'b0, 3'd0, 32'h009, 32'h0, 0, 1, 1'b1, 32'hFF71_8393);
    chk("lb_pos_rdata", r_rdata, 32'h0000_0083 | 32'hFFFF_FF00);

    // stores
    xfer(1'b1, 3'd0, 32'h012, 32'h0000_00AB, 0, 1, 1'b1, 32'h0);
    chk("sb_sel_we", {27'b0, r_we, r_sel}, 32'h0000_0014);
    chk("sb_data", r_data, 32'hABAB_ABAB);
    chk("sb_addr", {22'b0, r_addr}, 32'h010);
    chk("sb_rdata_kept", r_rdata, 32'hFFFF_FF83);
    xfer(1'b1, 3'd1, 32'h012, 32'h0000_1234, 0, 1, 1'b1, 32'h0);
    chk("sh_sel", {28'b0, r_sel}, 32'h0000_000C);
    chk("sh_data", r_data, 32'h1234_1234);
    xfer(1'b1, 3'd2, 32'h014, 32'hCAFE_F00D, 0, 0, 1'b1, 32'h0);
    chk("sw_ack_req_done_cyc", 32'(r_done_cyc), 32'd2);
    chk("sw_sel_data", {28'b0, r_sel} ^ r_data, 32'hCAFE_F002);

    // LW with 3 stall cycles, ack 2 cycles after acceptance
    xfer(1'b0, 3'd2, 32'h03C, 32'h0, 3, 2, 1'b1, 32'h1357_9BDF);
    chk("stall_done_cyc", 32'(r_done_cyc), 32'd7);
    chk("stall_stb_cycles", 32'(r_stb_cycles), 32'd4);
    chk("stall_cyc_cycles", 32'(r_cyc_cycles), 32'd6);
    chk("stall_addr_moved", {31'b0, r_moved}, 32'h0);
    chk("stall_rdata", r_rdata, 32'h1357_9BDF);

    // errors without bus activity
    xfer(1'b0, 3'd1, 32'h001, 32'h0, 0, 1, 1'b1, 32'h0);
    chk("lh_mis_done_cyc", 32'(r_done_cyc), 32'd1);
    chk("lh_mis_err", {31'b0, r_err}, 32'h1);
    chk("lh_mis_no_cyc", 32'(r_cyc_cycles), 32'd0);
    chk("lh_mis_rdata_kept", r_rdata, 32'h1357_9BDF);
    xfer(1'b0, 3'd3, 32'h000, 32'h0, 0, 1, 1'b1, 32'h0);
    chk("ld_f3_3_err", {r_done_cyc[30:0], r_err}, 32'h3);
    xfer(1'b1, 3'd2, 32'h002, 32'h0, 0, 1, 1'b1, 32'h0);
    chk("sw_mis_err", {r_done_cyc[30:0], r_err}, 32'h3);
    xfer(1'b1, 3'd4, 32'h000, 32'h0, 0, 1, 1'b1, 32'h0);
    chk("st_f3_4_err", {r_done_cyc[30:0], r_err}, 32'h3);

    // timeout: no ack ever
    xfer(1'b0, 3'd2, 32'h020, 32'h0, 0, 1, 1'b0, 32'h0);
    chk("to_done_cyc", 32'(r_done_cyc), 32'd17);
    chk("to_err", {31'b0, r_err}, 32'h1);
    chk("to_cyc_cycles", 32'(r_cyc_cycles), 32'd16);
    chk("to_rdata_kept", r_rdata, 32'h1357_9BDF);

    // reset mid-transfer, plus a request pulsed while busy
    i_we = 1'b0; i_funct3 = 3'd2; i_addr = 32'h040; i_req = 1'b1;
    tick();                                   // cycle 1
    chk("busy_in_req", {30'b0, o_busy, o_wb_cyc}, 32'h3);
    i_addr = 32'h3FC; i_req = 1'b1;
    tick();                                   // cycle 2
    i_req = 1'b0;
    chk("busy_req_ignored", {22'b0, o_wb_addr}, 32'h040);
    i_rst = 1'b1;
    tick();                                   // cycle 3
    i_rst = 1'b0;
    chk("rstmid_ctrl", {28'b0, o_busy, o_done, o_wb_cyc, o_wb_stb}, 32'h0);
    i_wb_ack = 1'b1; i_wb_data = 32'h5555_AAAA;
    tick();                                   // cycle 4
    i_wb_ack = 1'b0;
    chk("rstmid_late_ack", {29'b0, o_done, o_wb_cyc, o_busy}, 32'h0);
    chk("rstmid_rdata", o_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
